pc_gen_unit: RTL and testbench

Parametrised fetch-stage PC generator, replacing the fixed registered PC+4 adder in the 5-stage core. It holds the architectural fetch PC, advances it by 4, or by 2 for compressed instructions when C support is enabled, and applies trap and branch redirects with fixed priority. It supports fetch back-pressure and halt/resume. It also registers the accepted PC and its link address (PC+inc) into the IF/ID boundary.

---
 rtl/pc_gen_pkg.sv | 14 +
 rtl/pc_gen_unit_incr.sv | 22 ++
 rtl/pc_gen_unit.sv | 101 ++++++++++
 tb/tb_pc_gen_unit.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_gen_pkg.sv
// rtl/pc_gen_pkg.sv - shared state type, increments and target alignment check for the fetch PC generator
package pc_gen_pkg;

  typedef enum logic [1:0] {BOOT, RUN, HALT} pcg_state_t;

  localparam int INC_STD = 4;
  localparam int INC_C   = 2;

  // Targets need 4-byte alignment without compressed support, 2-byte with it.
  function automatic logic target_aligned(input logic [1:0] low, input logic c_ext);
    return !low[0] && (c_ext || !low[1]);
  endfunction

endpackage

// File: rtl/pc_gen_unit_incr.sv
// rtl/pc_gen_unit_incr.sv - sequential PC adder, +2 for compressed instructions when enabled, else +4
module pc_incr
  import pc_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter bit C_EXT = 1'b0
) (
  input  logic [XLEN-1:0] pc,
  input  logic            is_compressed,
  output logic [XLEN-1:0] sum
);

  logic [XLEN-1:0] inc;

  always_comb begin
    inc = (C_EXT && is_compressed) ? XLEN'(INC_C) : XLEN'(INC_STD);
  end

  // Modulo 2^XLEN: carry out of the top bit is intentionally dropped.
  assign sum = pc + inc;

endmodule

// File: rtl/pc_gen_unit.sv
// rtl/pc_gen_unit.sv - fetch PC generator with trap/branch redirect, back-pressure, halt and IF/ID register
module pc_gen_unit
  import pc_gen_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter bit              C_EXT        = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_ready,
  input  logic            is_compressed,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            trap_req,
  input  logic [XLEN-1:0] trap_vector,
  input  logic            halt_req,
  input  logic            resume,
  output logic [XLEN-1:0] pc_f,
  output logic            fetch_valid,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] link_d,
  output logic            valid_d,
  output logic            misalign_err,
  output logic [XLEN-1:0] misalign_addr
);

  pcg_state_t      state, state_nxt;
  logic [XLEN-1:0] pc_inc, pc_nxt, pc_d_nxt, link_nxt, mis_addr_nxt, trap_pc;
  logic            valid_nxt, mis_err_nxt;
  logic            accept, trap_hit, br_hit;

  pc_incr #(.XLEN(XLEN), .C_EXT(C_EXT)) u_incr (
    .pc            (pc_f),
    .is_compressed (is_compressed),
    .sum           (pc_inc)
  );

  assign fetch_valid = (state == RUN);
  assign accept      = fetch_valid && fetch_ready;
  assign trap_hit    = trap_req && (state != BOOT);
  assign br_hit      = br_taken && (state == RUN);
  assign trap_pc     = trap_vector & ~{{(XLEN-2){1'b0}}, 2'b11};

  always_comb begin
    state_nxt = state;
    unique case (state)
      BOOT:    state_nxt = RUN;
      RUN:     if (halt_req) state_nxt = HALT;
      HALT:    if (resume || trap_req) state_nxt = RUN;
      default: state_nxt = BOOT;
    endcase
  end

  // Redirects win over stalls; any redirect or misalign event flushes IF/ID.
  always_comb begin
    pc_nxt       = pc_f;
    pc_d_nxt     = pc_d;
    link_nxt     = link_d;
    valid_nxt    = 1'b0;
    mis_err_nxt  = 1'b0;
    mis_addr_nxt = misalign_addr;
    if (trap_hit) begin
      pc_nxt = trap_pc;
    end else if (br_hit && target_aligned(br_target[1:0], C_EXT)) begin
      pc_nxt = br_target;
    end else if (br_hit) begin
      mis_err_nxt  = 1'b1;
      mis_addr_nxt = br_target;
    end else if (accept) begin
      pc_nxt    = pc_inc;
      pc_d_nxt  = pc_f;
      link_nxt  = pc_inc;
      valid_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= BOOT;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_f          <= RESET_VECTOR;
      pc_d          <= '0;
      link_d        <= '0;
      valid_d       <= 1'b0;
      misalign_err  <= 1'b0;
      misalign_addr <= '0;
    end else begin
      pc_f          <= pc_nxt;
      pc_d          <= pc_d_nxt;
      link_d        <= link_nxt;
      valid_d       <= valid_nxt;
      misalign_err  <= mis_err_nxt;
      misalign_addr <= mis_addr_nxt;
    end
  end

endmodule

// File: tb/tb_pc_gen_unit.sv
// tb/tb_pc_gen_unit.sv - scoreboard bench for pc_gen_unit, C_EXT=0 and C_EXT=1 instances side by side
module tb_pc_gen_unit;

  localparam logic [31:0] RV0 = 32'h0000_0100;
  localparam logic [31:0] RV1 = 32'h0000_0200;

  logic clk = 1'b0;
  logic rst, fetch_ready, is_compressed, br_taken, trap_req, halt_req, resume;
  logic [31:0] br_target, trap_vector;

  logic [31:0] pc_f0, pc_d0, link_d0, ma0, pc_f1, pc_d1, link_d1, ma1;
  logic        fv0, vd0, me0, fv1, vd1, me1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pc_gen_unit #(.XLEN(32), .RESET_VECTOR(RV0), .C_EXT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .fetch_ready(fetch_ready), .is_compressed(is_compressed),
    .br_taken(br_taken), .br_target(br_target), .trap_req(trap_req), .trap_vector(trap_vector),
    .halt_req(halt_req), .resume(resume), .pc_f(pc_f0), .fetch_valid(fv0), .pc_d(pc_d0),
    .link_d(link_d0), .valid_d(vd0), .misalign_err(me0), .misalign_addr(ma0));

  pc_gen_unit #(.XLEN(32), .RESET_VECTOR(RV1), .C_EXT(1'b1)) dut1 (
    .clk(clk), .rst(rst), .fetch_ready(fetch_ready), .is_compressed(is_compressed),
    .br_taken(br_taken), .br_target(br_target), .trap_req(trap_req), .trap_vector(trap_vector),
    .halt_req(halt_req), .resume(resume), .pc_f(pc_f1), .fetch_valid(fv1), .pc_d(pc_d1),
    .link_d(link_d1), .valid_d(vd1), .misalign_err(me1), .misalign_addr(ma1));

  // Architectural view: mode 0 = booting, 1 = running, 2 = halted.
  typedef struct {
    int          mode;
    logic [31:0] pc, pcd, lnk, ma;
    bit          vd, me;
  } model_t;

  model_t m0, m1;
  model_t q0[$];
  model_t q1[$];

  function automatic model_t model_reset(logic [31:0] rv);
    model_t r;
    r.mode = 0; r.pc = rv; r.pcd = 0; r.lnk = 0; r.ma = 0; r.vd = 0; r.me = 0;
    return r;
  endfunction

  function automatic model_t model_step(model_t s, bit c);
    model_t n = s;
    bit running = (s.mode == 1);
    int unsigned step = (c && is_compressed) ? 2 : 4;
    bit bad = br_target[0] || (!c && br_target[1]);
    n.vd = 0;
    n.me = 0;
    if (s.mode != 0 && trap_req) n.pc = {trap_vector[31:2], 2'b00};
    else if (running && br_taken && !bad) n.pc = br_target;
    else if (running && br_taken) begin n.me = 1; n.ma = br_target; end
    else if (running && fetch_ready) begin
      n.pcd = s.pc;
      n.lnk = s.pc + step;
      n.pc  = s.pc + step;
      n.vd  = 1;
    end
    if (s.mode == 0) n.mode = 1;
    else if (s.mode == 1 && halt_req) n.mode = 2;
    else if (s.mode == 2 && (resume || trap_req)) n.mode = 1;
    return n;
  endfunction

  task automatic chk(string name, int d, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s dut%0d t=%0t got=%h exp=%h", name, d, $time, got, exp);
    end
  endtask

  task automatic cmp_all(int d, model_t e, logic [31:0] pf, logic fv, logic [31:0] pd,
                         logic [31:0] ld, logic vd, logic me, logic [31:0] ma);
    chk("pc_f", d, pf, e.pc);
    chk("fetch_valid", d, {31'b0, fv}, {31'b0, e.mode == 1});
    chk("pc_d", d, pd, e.pcd);
    chk("link_d", d, ld, e.lnk);
    chk("valid_d", d, {31'b0, vd}, {31'b0, e.vd});
    chk("misalign_err", d, {31'b0, me}, {31'b0, e.me});
    chk("misalign_addr", d, ma, e.ma);
  endtask

  // Monitor: every edge that has an expectation queued is compared 1 time unit later.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) cmp_all(0, q0.pop_front(), pc_f0, fv0, pc_d0, link_d0, vd0, me0, ma0);
      if (q1.size() > 0) cmp_all(1, q1.pop_front(), pc_f1, fv1, pc_d1, link_d1, vd1, me1, ma1);
    end
  end

  task automatic cycle();
    m0 = model_step(m0, 1'b0);
    m1 = model_step(m1, 1'b1);
    q0.push_back(m0);
    q1.push_back(m1);
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    fetch_ready = 0; is_compressed = 0; br_taken = 0; br_target = 0;
    trap_req = 0; trap_vector = 0; halt_req = 0; resume = 0;
  endtask

  task automatic branch(logic [31:0] t, logic rdy);
    br_taken = 1; br_target = t; fetch_ready = rdy;
    cycle();
    br_taken = 0;
  endtask

  task automatic reset_checks();
    cmp_all(0, model_reset(RV0), pc_f0, fv0, pc_d0, link_d0, vd0, me0, ma0);
    cmp_all(1, model_reset(RV1), pc_f1, fv1, pc_d1, link_d1, vd1, me1, ma1);
  endtask

  initial begin
    rst = 0;
    idle_inputs();
    m0 = model_reset(RV0);
    m1 = model_reset(RV1);
    repeat (2) @(posedge clk);
    #2;
    reset_checks();
    rst = 1;

    // Boot cycle, then sequential fetch with compressed pattern 1,0,1.
    fetch_ready = 1;
    cycle();
    is_compressed = 1; cycle();
    is_compressed = 0; cycle();
    is_compressed = 1; cycle();
    is_compressed = 0; cycle();

    // Branch while stalled, then hold until ready.
    branch(32'h40, 1'b1);
    branch(32'h80, 1'b0);
    fetch_ready = 0; cycle(); cycle();
    fetch_ready = 1; cycle();

    // Trap beats branch in the same cycle.
    trap_req = 1; trap_vector = 32'h1003; br_taken = 1; br_target = 32'h500;
    cycle();
    trap_req = 0; br_taken = 0; cycle();

    // Misaligned targets back-to-back, then wrap from the top of the address space.
    branch(32'h302, 1'b1);
    branch(32'h301, 1'b1);
    cycle();
    branch(32'hFFFF_FFFC, 1'b1);
    is_compressed = 0; cycle(); cycle();

    // Halt, branch ignored while halted, simultaneous halt/resume, then resume.
    halt_req = 1; cycle();
    halt_req = 0; branch(32'h700, 1'b1);
    cycle();
    halt_req = 1; resume = 1; cycle();
    halt_req = 0; resume = 0; cycle(); cycle();
    halt_req = 1; cycle();
    halt_req = 0; trap_req = 1; trap_vector = 32'h0000_0A06; cycle();
    trap_req = 0; cycle();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      fetch_ready   = ($urandom_range(99) < 75);
      is_compressed = $urandom_range(1);
      br_taken      = ($urandom_range(99) < 15);
      br_target     = $urandom;
      trap_req      = ($urandom_range(99) < 4);
      trap_vector   = $urandom;
      halt_req      = ($urandom_range(99) < 5);
      resume        = ($urandom_range(99) < 25);
      cycle();
    end

    // Asynchronous reset mid-run.
    idle_inputs();
    fetch_ready = 1;
    cycle(); cycle();
    rst = 0;
    #1;
    m0 = model_reset(RV0);
    m1 = model_reset(RV1);
    reset_checks();
    @(posedge clk);
    #2;
    reset_checks();
    rst = 1;
    cycle(); cycle(); cycle();

    @(posedge clk);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
